// File: rtl/backscatter_pkg.sv
// backscatter_pkg: shared state encoding, default timing and whitening constants for the backscatter TX sequencer.
package backscatter_pkg;
  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, GAP} state_t;
  localparam int DEF_CLK_PER_BIT = 24;
  localparam int DEF_PREAMBLE_BITS = 8;
  localparam int DEF_GAP_CYCLES = 2400;
  localparam logic [6:0] WHITEN_POLY = 7'h11;
  function automatic logic [6:0] lfsr_next(input logic [6:0] s);
    return {s[5:0], 1'b0} ^ (s[6] ? WHITEN_POLY : 7'h00);
  endfunction
endpackage

// File: rtl/backscatter_tx_sequencer_bit_slot_timer.sv
// bit_slot_timer: free-running bit-slot counter with synchronous clear and a slot_last flag on the final cycle.
module bit_slot_timer #(
  parameter int CLK_PER_BIT = 24
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic slot_last
);
  localparam int W = $clog2(CLK_PER_BIT);
  logic [W-1:0] cnt;
  assign slot_last = cnt == W'(CLK_PER_BIT - 1);
  always_ff @(posedge clock or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= (clear || slot_last) ? '0 : cnt + W'(1);
endmodule

// File: rtl/backscatter_tx_sequencer.sv
// backscatter_tx_sequencer: preamble/payload/gap frame sequencer for the backscatter modulator.
// Define BACKSCATTER_TX_WHITEN_EN to XOR payload bits with a BLE whitening LFSR.
module backscatter_tx_sequencer
  import backscatter_pkg::*;
#(
  parameter int CLK_PER_BIT = DEF_CLK_PER_BIT,
  parameter int PREAMBLE_BITS = DEF_PREAMBLE_BITS,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int LEN_W = 8,
  parameter int REP_W = 4
`ifdef BACKSCATTER_TX_WHITEN_EN
  , parameter logic [6:0] WHITEN_SEED = 7'h53
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [REP_W-1:0] cfg_repeat,
  input  logic             bit_valid,
  input  logic             bit_data,
  output logic             bit_ready,
  output logic             mod_trigger,
  output logic             tone_sel,
  output logic             busy,
  output logic             done,
  output logic             underrun
);
  localparam int PRE_W = $clog2(PREAMBLE_BITS + 1);
  state_t state;
  logic [LEN_W-1:0] len_q, bit_cnt;
  logic [REP_W-1:0] rep_cnt;
  logic [15:0] gap_cnt;
  logic [PRE_W-1:0] pre_cnt;
  logic slot_last, timer_clear, fetch_slot, in_bit;
  assign timer_clear = state == IDLE || state == GAP;
  bit_slot_timer #(.CLK_PER_BIT(CLK_PER_BIT)) u_timer (
    .clock(clock),
    .reset(reset),
    .clear(timer_clear),
    .slot_last(slot_last)
  );
  // A fetch belongs to the slot before every payload slot, including the last preamble slot.
  assign fetch_slot = (state == PREAMBLE && pre_cnt == PRE_W'(PREAMBLE_BITS - 1)) ||
                      (state == PAYLOAD && bit_cnt != len_q - LEN_W'(1));
  assign bit_ready = slot_last && fetch_slot;
  assign busy = state != IDLE;
`ifdef BACKSCATTER_TX_WHITEN_EN
  logic [6:0] lfsr;
  assign in_bit = bit_data ^ lfsr[6];
  always_ff @(posedge clock or negedge reset)
    if (!reset) lfsr <= '0;
    else if ((state == IDLE && start) || (state == GAP && gap_cnt == 16'(GAP_CYCLES - 1))) lfsr <= WHITEN_SEED;
    else if (bit_ready && bit_valid) lfsr <= lfsr_next(lfsr);
`else
  assign in_bit = bit_data;
`endif
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      len_q <= '0;
      bit_cnt <= '0;
      rep_cnt <= '0;
      gap_cnt <= '0;
      pre_cnt <= '0;
      mod_trigger <= 1'b0;
      tone_sel <= 1'b0;
      done <= 1'b0;
      underrun <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          len_q <= cfg_len;
          underrun <= 1'b0;
          gap_cnt <= '0;
          pre_cnt <= '0;
          bit_cnt <= '0;
          rep_cnt <= cfg_len == '0 ? '0 : cfg_repeat;
          state <= cfg_len == '0 ? GAP : PREAMBLE;
          mod_trigger <= cfg_len != '0;
          tone_sel <= cfg_len != '0;
        end
      end else if (state == GAP) begin
        if (gap_cnt == 16'(GAP_CYCLES - 1)) begin
          gap_cnt <= '0;
          pre_cnt <= '0;
          if (rep_cnt != '0) begin
            rep_cnt <= rep_cnt - REP_W'(1);
            state <= PREAMBLE;
            mod_trigger <= 1'b1;
            tone_sel <= 1'b1;
          end else begin
            state <= IDLE;
            done <= 1'b1;
          end
        end else gap_cnt <= gap_cnt + 16'd1;
      end else if (slot_last) begin
        if (bit_ready && !bit_valid) begin
          underrun <= 1'b1;
          rep_cnt <= '0;
          state <= GAP;
          gap_cnt <= '0;
          mod_trigger <= 1'b0;
          tone_sel <= 1'b0;
        end else if (bit_ready) begin
          bit_cnt <= state == PAYLOAD ? bit_cnt + LEN_W'(1) : '0;
          state <= PAYLOAD;
          tone_sel <= in_bit;
        end else if (state == PAYLOAD) begin
          state <= GAP;
          gap_cnt <= '0;
          mod_trigger <= 1'b0;
          tone_sel <= 1'b0;
        end else begin
          pre_cnt <= pre_cnt + PRE_W'(1);
          tone_sel <= ~tone_sel;
        end
      end
    end
  end
endmodule

// File: tb/tb_backscatter_tx_sequencer.sv
// tb_backscatter_tx_sequencer: directed checks of frame timing, repeats, underrun, empty frames and reset.
module tb_backscatter_tx_sequencer;
  logic clock = 1'b0, reset, start;
  logic [7:0] cfg_len;
  logic [3:0] cfg_repeat;
  logic bit_valid, bit_data, bit_ready, mod_trigger, tone_sel, busy, done, underrun;
  logic [63:0] pat;
  int fetch_idx = 0, fetch_base, drop_at, rel;
  int mt_cnt = 0, hs_cnt = 0, dn_cnt = 0;
  int mt0, hs0, dn0, n;
  int checks = 0, failures = 0;
  logic [11:0] exp1 = 12'b101010101101;

  backscatter_tx_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .cfg_len(cfg_len), .cfg_repeat(cfg_repeat),
    .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(bit_ready), .mod_trigger(mod_trigger),
    .tone_sel(tone_sel), .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clock = ~clock;
  assign rel = fetch_idx - fetch_base;
  assign bit_valid = rel != drop_at;
  assign bit_data = pat[rel[5:0]];
  always @(posedge clock) if (bit_ready) fetch_idx <= fetch_idx + 1;
  always @(negedge clock) begin
    if (mod_trigger) mt_cnt <= mt_cnt + 1;
    if (bit_ready && bit_valid) hs_cnt <= hs_cnt + 1;
    if (done) dn_cnt <= dn_cnt + 1;
  end

  task automatic tick(input int k);
    repeat (k) @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int max, output int cnt);
    cnt = 0;
    while (!done && cnt < max) begin
      tick(1);
      cnt++;
    end
  endtask

  task automatic snap();
    fetch_base = fetch_idx;
    mt0 = mt_cnt;
    hs0 = hs_cnt;
    dn0 = dn_cnt;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; cfg_len = '0; cfg_repeat = '0; pat = '0; fetch_base = 0; drop_at = 1000;
    tick(3);
    chk("rst_mod", mod_trigger, 0);
    chk("rst_tone", tone_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_ready", bit_ready, 0);
    reset = 1'b1;
    tick(2);
    // single frame, len 4, data 1,1,0,1
    pat = 64'hB; snap();
    start = 1'b1; cfg_len = 8'd4; cfg_repeat = 4'd0;
    tick(1); start = 1'b0;
    chk("t1_busy", busy, 1);
    chk("t1_mod", mod_trigger, 1);
    for (int k = 0; k < 12; k++) begin
      if (k != 0) tick(24);
      chk($sformatf("t1_tone%0d", k), tone_sel, exp1[11-k]);
    end
    tick(24);
    chk("t1_mod_fall", mod_trigger, 0);
    chk("t1_tone_fall", tone_sel, 0);
    chk("t1_busy_gap", busy, 1);
    tick(2399);
    chk("t1_done_early", done, 0);
    chk("t1_busy_end", busy, 1);
    tick(1);
    chk("t1_done", done, 1);
    chk("t1_busy_fall", busy, 0);
    tick(1);
    chk("t1_done_pulse", done, 0);
    chk("t1_mod_cycles", mt_cnt - mt0, 288);
    chk("t1_handshakes", hs_cnt - hs0, 4);
    chk("t1_done_count", dn_cnt - dn0, 1);
    // three frames of len 2, with an ignored start during the first gap
    pat = '1; snap();
    start = 1'b1; cfg_len = 8'd2; cfg_repeat = 4'd2;
    tick(1); start = 1'b0;
    tick(239);
    chk("t2_burst_end", mod_trigger, 1);
    tick(1);
    chk("t2_gap_start", mod_trigger, 0);
    tick(760);
    start = 1'b1; cfg_len = 8'd5; cfg_repeat = 4'd7;
    tick(1); start = 1'b0;
    chk("t2_busy_start_busy", busy, 1);
    chk("t2_busy_start_mod", mod_trigger, 0);
    tick(1638);
    chk("t2_gap_end", mod_trigger, 0);
    tick(1);
    chk("t2_burst2", mod_trigger, 1);
    wait_done(6000, n);
    chk("t2_done_time", n, 5280);
    tick(1);
    chk("t2_mod_cycles", mt_cnt - mt0, 720);
    chk("t2_handshakes", hs_cnt - hs0, 6);
    chk("t2_done_count", dn_cnt - dn0, 1);
    // underrun on the third fetch; repeats discarded
    pat = '1; snap(); drop_at = 2;
    start = 1'b1; cfg_len = 8'd8; cfg_repeat = 4'd1;
    tick(1); start = 1'b0;
    tick(239);
    chk("t3_mod_pre", mod_trigger, 1);
    chk("t3_ready", bit_ready, 1);
    chk("t3_valid", bit_valid, 0);
    chk("t3_underrun_pre", underrun, 0);
    tick(1);
    chk("t3_underrun", underrun, 1);
    chk("t3_mod_drop", mod_trigger, 0);
    chk("t3_tone_drop", tone_sel, 0);
    chk("t3_busy", busy, 1);
    wait_done(3000, n);
    chk("t3_done_time", n, 2400);
    tick(1);
    drop_at = 1000;
    chk("t3_underrun_held", underrun, 1);
    chk("t3_idle", busy, 0);
    chk("t3_mod_cycles", mt_cnt - mt0, 240);
    chk("t3_handshakes", hs_cnt - hs0, 2);
    chk("t3_done_count", dn_cnt - dn0, 1);
    // empty frame
    snap();
    start = 1'b1; cfg_len = 8'd0; cfg_repeat = 4'd3;
    tick(1); start = 1'b0;
    chk("t4_underrun_clr", underrun, 0);
    chk("t4_busy", busy, 1);
    chk("t4_mod", mod_trigger, 0);
    wait_done(3000, n);
    chk("t4_done_time", n, 2400);
    tick(1);
    chk("t4_idle", busy, 0);
    chk("t4_mod_cycles", mt_cnt - mt0, 0);
    chk("t4_done_count", dn_cnt - dn0, 1);
    // asynchronous reset mid-payload, then a fresh sequence
    pat = 64'hB; snap();
    start = 1'b1; cfg_len = 8'd4; cfg_repeat = 4'd0;
    tick(1); start = 1'b0;
    tick(200);
    chk("t5_mod_pre", mod_trigger, 1);
    reset = 1'b0;
    #1;
    chk("t5_rst_mod", mod_trigger, 0);
    chk("t5_rst_tone", tone_sel, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ready", bit_ready, 0);
    tick(2);
    reset = 1'b1;
    tick(2);
    chk("t5_no_done", dn_cnt - dn0, 0);
    snap();
    start = 1'b1;
    tick(1); start = 1'b0;
    chk("t5_restart_mod", mod_trigger, 1);
    chk("t5_restart_tone", tone_sel, 1);
    tick(192);
    chk("t5_pay0", tone_sel, 1);
    tick(48);
    chk("t5_pay2", tone_sel, 0);
    wait_done(5000, n);
    chk("t5_done_time", n, 2448);
    tick(1);
    chk("t5_mod_cycles", mt_cnt - mt0, 288);
    chk("t5_done_count", dn_cnt - dn0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/backscatter_tx_sequencer.md
Name: backscatter_tx_sequencer

Overview:
Frame-level controller for the backscatter modulator. On a start request it sequences one or more frames. Each frame is a fixed alternating preamble, a payload of cfg_len bits pulled from an upstream bit source, and an inter-frame gap. It drives the modulator enable (mod_trigger) and the per-bit tone select (tone_sel), and reports busy, done and underrun to the host logic.

Parameters:
CLK_PER_BIT, 24, clock cycles per bit slot (>=2)
PREAMBLE_BITS, 8, preamble length in bits (>=1)
GAP_CYCLES, 2400, inter-frame gap in cycles with mod_trigger low (1..65535)
LEN_W, 8, width of cfg_len
REP_W, 4, width of cfg_repeat
WHITEN_SEED, 7'h53, LFSR seed (used only with the optional feature)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  frame request; sampled only in IDLE
cfg_len  in  LEN_W  payload bits per frame; latched on start
cfg_repeat  in  REP_W  extra frames after the first; latched on start
bit_valid  in  1  upstream payload bit available
bit_data  in  1  upstream payload bit
bit_ready  out  1  sequencer consumes bit_data this cycle if bit_valid
mod_trigger  out  1  modulator enable; high through preamble and payload
tone_sel  out  1  current bit value presented to the modulator
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when the sequence completes
underrun  out  1  sticky: payload bit was not available when required

Behaviour:
- Reset value of every output and register is 0; state is IDLE. Reset mid-frame drops mod_trigger immediately (asynchronous), with no done pulse.
- States: IDLE, PREAMBLE, PAYLOAD, GAP.
- IDLE, start=1 at cycle T: latch cfg_len and cfg_repeat, clear underrun. At T+1: state PREAMBLE, busy=1, mod_trigger=1, tone_sel=1.
- IDLE, start=1 with cfg_len=0: go to GAP directly; mod_trigger stays 0; done pulses at the end of the gap. cfg_repeat is ignored in this case.
- start while busy is ignored.
- A bit-slot timer counts 0..CLK_PER_BIT-1. tone_sel changes only on the cycle the timer wraps to 0.
- PREAMBLE: tone_sel follows 1,0,1,0,... for PREAMBLE_BITS slots.
- Bit fetch: bit_ready=1 for exactly one cycle, at timer=CLK_PER_BIT-1 of any slot whose next slot is a payload slot. That includes the last preamble slot.
  - Fetch with bit_valid=1: bit_data becomes tone_sel on the next cycle, when the new slot begins.
  - Fetch with bit_valid=0: set underrun, force mod_trigger=0 and tone_sel=0 on the next cycle, clear remaining repeats, go to GAP.
- PAYLOAD: cfg_len slots. After the last slot, go to GAP: mod_trigger=0, tone_sel=0.
- GAP: lasts GAP_CYCLES cycles.
  - If the repeat counter is nonzero: decrement it and return to PREAMBLE; payload bits are fetched afresh.
  - Otherwise: return to IDLE and pulse done in the same cycle the state becomes IDLE; busy falls on that cycle.
- Frame timing: mod_trigger stays high for exactly (PREAMBLE_BITS+cfg_len)*CLK_PER_BIT contiguous cycles per frame.
- Counter widths: slot timer $clog2(CLK_PER_BIT); bit counter LEN_W; gap counter 16 bits; repeat counter REP_W. No wrap-around is possible within the legal ranges.

Optional Feature:
- Macro: BACKSCATTER_TX_WHITEN_EN.
- Defined: accepted payload bits are XORed with the output of a BLE whitening LFSR (x^7+x^4+1). The LFSR is loaded with WHITEN_SEED on every PREAMBLE entry and advances once per accepted bit. Preamble bits are never whitened.
- Undefined: no LFSR logic; tone_sel = bit_data, unmodified.

Decomposition:
- Shared package backscatter_pkg:
  - state enum (IDLE/PREAMBLE/PAYLOAD/GAP)
  - default constants for CLK_PER_BIT, PREAMBLE_BITS, GAP_CYCLES
  - BLE whitening polynomial constant
- One sub-module: bit_slot_timer. It holds the slot counter, emits a slot_last pulse at CLK_PER_BIT-1, and has a synchronous clear input.

Test Plan:
- cfg_len=4, cfg_repeat=0, data 1,1,0,1 always valid -> mod_trigger high 288 cycles; tone_sel sequence 1,0,1,0,1,0,1,0,1,1,0,1 (24 cycles each); done pulses 2400 cycles after mod_trigger falls.
- cfg_len=2, cfg_repeat=2 -> three 240-cycle mod_trigger bursts separated by 2400-cycle gaps; exactly 6 bit_ready/valid handshakes; one done pulse.
- bit_valid dropped at the 3rd fetch of cfg_len=8 -> underrun=1 and mod_trigger=0 one cycle after the failed fetch; done after 2400 cycles; underrun held until the next start.
- start with cfg_len=0 -> mod_trigger never asserted; busy for 2400 cycles; done pulse.
- Reset asserted mid-PAYLOAD -> all outputs 0 immediately; a start after release behaves as a fresh sequence. A start pulse during busy has no effect.
- BACKSCATTER_TX_WHITEN_EN defined, WHITEN_SEED=7'h53, 8 zero bits -> tone_sel equals the first 8 LFSR output bits; preamble unchanged.
